afifo_rd_burst: RTL and testbench

- Read-side consumer for the async FIFO, living entirely in the read-clock domain.
- Pops words through the FIFO's show-ahead interface (fifo_rdata valid whenever fifo_empty=0; fifo_ren advances the pointer) and presents them as a valid/ready stream.
- Output is framed into fixed-length bursts with m_last.
- Enable/stop control always finishes the current burst before going idle, so downstream never sees a truncated burst.

---
 rtl/afifo_rd_pkg.sv | 23 ++
 rtl/afifo_rd_skid.sv | 70 +++++++
 rtl/afifo_rd_burst.sv | 145 ++++++++++++++
 tb/tb_afifo_rd_burst.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_rd_pkg.sv
// Shared types for the async-FIFO read-side burst consumer.
// Parity storage per entry exists only when AFIFO_RD_PARITY_EN is defined.
package afifo_rd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP, DRAIN} state_t;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_PTR_W = $clog2(BUF_DEPTH);
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  // Per-entry sideband; the data word is sized by the instantiating module.
  typedef struct packed {
    logic last;
`ifdef AFIFO_RD_PARITY_EN
    logic parity;
`endif
  } entry_tag_t;

  function automatic logic [BUF_PTR_W-1:0] ptr_inc(input logic [BUF_PTR_W-1:0] p);
    return (p == BUF_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + BUF_PTR_W'(1);
  endfunction

endpackage

// File: rtl/afifo_rd_skid.sv
// Small circular buffer between FIFO pops and the valid/ready output.
// Holds {data, tag}; head is always presented, count tells the owner how full it is.
module afifo_rd_skid
  import afifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  entry_tag_t            push_tag,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output entry_tag_t            head_tag,
  output logic [BUF_CNT_W-1:0]  count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    entry_tag_t            tag;
  } entry_t;

  entry_t                mem_q [BUF_DEPTH];
  entry_t                mem_d [BUF_DEPTH];
  logic [BUF_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BUF_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BUF_CNT_W-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{data: push_data, tag: push_tag};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + BUF_CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - BUF_CNT_W'(1);
    end
  end

  // Entries are cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q].data;
  assign head_tag  = mem_q[rd_ptr_q].tag;
  assign count     = count_q;

endmodule

// File: rtl/afifo_rd_burst.sv
// Read-domain consumer: pops a show-ahead FIFO and emits fixed-length bursts on valid/ready.
// Define AFIFO_RD_PARITY_EN to add the m_parity output carried alongside each word.
module afifo_rd_burst
  import afifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_ren,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  burst_done,
  output logic [CNT_WIDTH-1:0]  burst_cnt
`ifdef AFIFO_RD_PARITY_EN
  ,
  output logic                  m_parity
`endif
);

  localparam int            FW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [FW-1:0] LAST_IDX = FW'(BURST_LEN - 1);

  state_t                state_q, state_d;
  logic [FW-1:0]         fetch_cnt_q, fetch_cnt_d;
  logic [FW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;
  logic                  pop_ok, pop, accept, fetch_at_last;
  logic [BUF_CNT_W-1:0]  count;
  logic [DATA_WIDTH-1:0] head_data;
  entry_tag_t            push_tag, head_tag;

  assign fetch_at_last = (fetch_cnt_q == LAST_IDX);
  assign pop           = pop_ok && !fifo_empty && (count != BUF_CNT_W'(BUF_DEPTH));
  assign accept        = m_valid && m_ready;

  always_comb begin
    push_tag      = '0;
    push_tag.last = fetch_at_last;
`ifdef AFIFO_RD_PARITY_EN
    push_tag.parity = ^fifo_rdata;
`endif
  end

  afifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (rclk),
    .rst       (rrst),
    .push      (pop),
    .push_data (fifo_rdata),
    .push_tag  (push_tag),
    .pop       (accept),
    .head_data (head_data),
    .head_tag  (head_tag),
    .count     (count)
  );

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving RUN goes straight to DRAIN only when this cycle sits on a burst boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (en) state_d = RUN;
      RUN: begin
        if (!en) begin
          if (pop ? fetch_at_last : (fetch_cnt_q == '0)) state_d = DRAIN;
          else                                           state_d = STOP;
        end
      end
      STOP: begin
        if (en)                        state_d = RUN;
        else if (pop && fetch_at_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (en)                 state_d = RUN;
        else if (count == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_ok = 1'b0;
    busy   = 1'b1;
    case (state_q)
      IDLE:      busy   = 1'b0;
      RUN, STOP: pop_ok = 1'b1;
      default:   pop_ok = 1'b0;
    endcase
  end

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    if (pop) begin
      fetch_cnt_d = fetch_at_last ? '0 : fetch_cnt_q + FW'(1);
    end
    if (accept) begin
      beat_cnt_d = (beat_cnt_q == LAST_IDX) ? '0 : beat_cnt_q + FW'(1);
    end
    if (accept && m_last) begin
      burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      fetch_cnt_q <= '0;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign fifo_ren   = pop;
  assign m_valid    = (count != '0);
  assign m_data     = head_data;
  assign m_last     = head_tag.last;
  assign burst_done = accept && m_last;
  assign burst_cnt  = burst_cnt_q;
`ifdef AFIFO_RD_PARITY_EN
  assign m_parity   = head_tag.parity;
`endif

endmodule

// File: tb/tb_afifo_rd_burst.sv
// Directed bench for afifo_rd_burst: a cycle table for streaming plus hand sequences
// for backpressure, reset, stop-at-boundary and underrun (parity when AFIFO_RD_PARITY_EN).
module tb_afifo_rd_burst;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 16;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty, fifo_ren, m_valid, m_last, busy, burst_done;
  logic [DW-1:0] fifo_rdata, m_data;
  logic [CW-1:0] burst_cnt;
`ifdef AFIFO_RD_PARITY_EN
  logic          m_parity;
`endif

  int nChecks = 0;
  int nFail = 0;

  // Show-ahead FIFO model and output monitor.
  logic [7:0] fifoMem [64];
  int         fifoRd = 0;
  int         fifoWr = 0;
  int         popCount = 0;
  int         accCount = 0;
  logic [7:0] accData [64];
  logic       accLast [64];

  assign fifo_empty = (fifoRd == fifoWr);
  assign fifo_rdata = fifoMem[fifoRd[5:0]];

  afifo_rd_burst #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .CNT_WIDTH (CW)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .burst_done (burst_done),
    .burst_cnt  (burst_cnt)
`ifdef AFIFO_RD_PARITY_EN
    ,
    .m_parity   (m_parity)
`endif
  );

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (!rrst) begin
      if (fifo_ren) begin
        fifoRd   <= fifoRd + 1;
        popCount <= popCount + 1;
      end
      if (m_valid && m_ready) begin
        accData[accCount[5:0]] <= m_data;
        accLast[accCount[5:0]] <= m_last;
        accCount               <= accCount + 1;
      end
    end
  end

  typedef struct {
    logic        en;
    logic        m_ready;
    logic        expRen;
    logic        expValid;
    logic [7:0]  expData;
    logic        expLast;
    logic        expDone;
    logic        expBusy;
    logic [15:0] expCnt;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [7:0] wordVal(input int i);
    return 8'(8'h05 + 8'h11 * i);
  endfunction

  function automatic int countLasts(input int start, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (accLast[(start + i) % 64]) c++;
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic r);
    @(negedge rclk);
    en      = e;
    m_ready = r;
    #1;
  endtask

  task automatic pushWord(input logic [7:0] w);
    fifoMem[fifoWr[5:0]] = w;
    fifoWr++;
  endtask

  task automatic flushFifo();
    fifoWr = fifoRd;
  endtask

  task automatic resetDut();
    rrst    = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
    #1;
  endtask

  task automatic waitAcc(input int target, input int budget, input string name);
    int n = 0;
    while (accCount < target && n < budget) begin
      @(negedge rclk);
      #1;
      n++;
    end
    checkOutput(name, 32'(accCount >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accStart;
    int popStart;
    int unstable;
    int busyLow;
    int lastSeen;

    // Streaming burst table: 8 preloaded words, en=1, m_ready=1.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h27, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h38, 1'b1, 1'b1, 1'b1, 16'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h49, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h7C, 1'b1, 1'b1, 1'b1, 16'd1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd2};

    resetDut();
    for (int i = 0; i < 8; i++) pushWord(wordVal(i));
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].en, vecs[i].m_ready);
      checkOutput($sformatf("row%0d_ren", i), 32'(fifo_ren), 32'(vecs[i].expRen));
      checkOutput($sformatf("row%0d_valid", i), 32'(m_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("row%0d_done", i), 32'(burst_done), 32'(vecs[i].expDone));
      checkOutput($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("row%0d_cnt", i), 32'(burst_cnt), 32'(vecs[i].expCnt));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("row%0d_data", i), 32'(m_data), 32'(vecs[i].expData));
        checkOutput($sformatf("row%0d_last", i), 32'(m_last), 32'(vecs[i].expLast));
      end
    end

    // Backpressure: 6 words, m_ready low for 10 cycles, then release.
    for (int i = 0; i < 6; i++) pushWord(wordVal(10 + i));
    popStart = popCount;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (m_valid && m_data !== wordVal(10)) unstable++;
    end
    checkOutput("bp_pops", 32'(popCount - popStart), 32'd2);
    checkOutput("bp_ren_low", 32'(fifo_ren), 32'd0);
    checkOutput("bp_valid", 32'(m_valid), 32'd1);
    checkOutput("bp_hold_data", 32'(m_data), 32'(wordVal(10)));
    checkOutput("bp_stable", 32'(unstable), 32'd0);
    accStart = accCount;
    applyStimulus(1'b1, 1'b1);
    waitAcc(accStart + 6, 30, "bp_release_wait");
    repeat (3) applyStimulus(1'b1, 1'b1);
    checkOutput("bp_acc_count", 32'(accCount - accStart), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("bp_word%0d", i), 32'(accData[(accStart + i) % 64]), 32'(wordVal(10 + i)));
    end
    checkOutput("bp_last3", 32'(accLast[(accStart + 3) % 64]), 32'd1);
    checkOutput("bp_last_total", 32'(countLasts(accStart, 6)), 32'd1);
    checkOutput("bp_burst_cnt", 32'(burst_cnt), 32'd3);

    // Asynchronous reset with the buffer full.
    for (int i = 0; i < 4; i++) pushWord(wordVal(30 + i));
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("rst_pre_valid", 32'(m_valid), 32'd1);
    checkOutput("rst_pre_ren", 32'(fifo_ren), 32'd0);
    rrst = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_ren", 32'(fifo_ren), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cnt", 32'(burst_cnt), 32'd0);
    checkOutput("rst_data", 32'(m_data), 32'd0);
    checkOutput("rst_last", 32'(m_last), 32'd0);
    checkOutput("rst_done", 32'(burst_done), 32'd0);
    applyStimulus(1'b0, 1'b1);
    @(negedge rclk);
    rrst = 1'b0;
    #1;
    popStart = popCount;
    repeat (5) applyStimulus(1'b0, 1'b1);
    checkOutput("rst_idle_pops", 32'(popCount - popStart), 32'd0);
    checkOutput("rst_idle_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_idle_busy", 32'(busy), 32'd0);
    flushFifo();

    // Stop mid-burst: en drops while beat 1 is on the output.
    resetDut();
    flushFifo();
    for (int i = 0; i < 8; i++) pushWord(wordVal(20 + i));
    accStart = accCount;
    applyStimulus(1'b1, 1'b1);
    waitAcc(accStart + 1, 20, "stop_wait_beat1");
    checkOutput("stop_beat1_data", 32'(m_data), 32'(wordVal(21)));
    en = 1'b0;
    #1;
    repeat (10) applyStimulus(1'b0, 1'b1);
    checkOutput("stop_acc_count", 32'(accCount - accStart), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("stop_word%0d", i), 32'(accData[(accStart + i) % 64]), 32'(wordVal(20 + i)));
    end
    checkOutput("stop_last3", 32'(accLast[(accStart + 3) % 64]), 32'd1);
    checkOutput("stop_last_total", 32'(countLasts(accStart, 4)), 32'd1);
    checkOutput("stop_busy", 32'(busy), 32'd0);
    checkOutput("stop_fifo_left", 32'(fifoWr - fifoRd), 32'd4);
    checkOutput("stop_burst_cnt", 32'(burst_cnt), 32'd1);

    // FIFO underrun inside a burst.
    resetDut();
    flushFifo();
    pushWord(wordVal(40));
    pushWord(wordVal(41));
    accStart = accCount;
    busyLow  = 0;
    lastSeen = 0;
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (i > 0 && !busy) busyLow++;
      if (m_valid && m_last) lastSeen++;
    end
    checkOutput("ur_stall_acc", 32'(accCount - accStart), 32'd2);
    checkOutput("ur_busy_low", 32'(busyLow), 32'd0);
    checkOutput("ur_no_early_last", 32'(lastSeen), 32'd0);
    checkOutput("ur_cnt_mid", 32'(burst_cnt), 32'd0);
    pushWord(wordVal(42));
    pushWord(wordVal(43));
    waitAcc(accStart + 4, 20, "ur_resume_wait");
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ur_word%0d", i), 32'(accData[(accStart + i) % 64]), 32'(wordVal(40 + i)));
    end
    checkOutput("ur_last3", 32'(accLast[(accStart + 3) % 64]), 32'd1);
    checkOutput("ur_last_total", 32'(countLasts(accStart, 4)), 32'd1);
    checkOutput("ur_burst_cnt", 32'(burst_cnt), 32'd1);
    checkOutput("ur_busy_end", 32'(busy), 32'd1);

`ifdef AFIFO_RD_PARITY_EN
    resetDut();
    flushFifo();
    checkOutput("par_reset", 32'(m_parity), 32'd0);
    pushWord(8'hA5);
    pushWord(8'h01);
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("par_a5_data", 32'(m_data), 32'h0A5);
    checkOutput("par_a5", 32'(m_parity), 32'd0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("par_01_data", 32'(m_data), 32'h001);
    checkOutput("par_01", 32'(m_parity), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
